seg_scan_demux: RTL and testbench

Display-side demultiplexer and scan driver for the 8-digit 7-segment display. It takes per-digit segment patterns through a simple write port and stores them in eight digit registers. It then time-multiplexes them onto one shared segment bus, driving a 3-bit digit index and active-low digit enables. A programmable blanking gap at each digit change suppresses ghosting. It sits between the pattern-generation logic and the display pins, and is the distributing counterpart of the display's pattern-select mux.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_digit_regfile.sv | 42 ++++
 rtl/seg_scan_demux.sv | 137 +++++++++++++
 tb/tb_seg_scan_demux.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, state encoding and helpers for the 8-digit 7-segment scan driver.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int IDX_W      = 3;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF_N = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Active-low one-cold enable for the digit at idx.
  function automatic logic [NUM_DIGITS-1:0] digit_enable_n(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = NUM_DIGITS'(1) << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg_digit_regfile.sv
// Eight 7-bit digit pattern registers with write demux, global clear and
// a combinational read port selected by digit index.
module seg_digit_regfile
  import seg_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [SEG_W-1:0] wr_data,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [SEG_W-1:0] rd_data
);

  logic [NUM_DIGITS-1:0][SEG_W-1:0] digit_bank;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic             sel;
      logic [SEG_W-1:0] digit_q;

      assign sel = wr_en && (wr_addr == IDX_W'(gi));

      // Clear has priority so a simultaneous write cannot survive it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          digit_q <= SEG_BLANK;
        end else if (clr_all) begin
          digit_q <= SEG_BLANK;
        end else if (sel) begin
          digit_q <= wr_data;
        end
      end

      assign digit_bank[gi] = digit_q;
    end
  endgenerate

  assign rd_data = digit_bank[rd_idx];

endmodule

// File: rtl/seg_scan_demux.sv
// Digit scan driver: stores eight segment patterns and time-multiplexes them
// onto a shared segment bus with a blanking gap at every digit change.
module seg_scan_demux
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [SEG_W-1:0]      wr_data,
  input  logic                  clr_all,
  input  logic                  scan_en,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_en_n,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // Reset asserts asynchronously; release is delayed through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [SEG_W-1:0]      rd_data;

  seg_digit_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_all (clr_all),
    .rd_idx  (idx_d),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    if (!scan_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs derive from next-state so they change on the same edge as the FSM.
  always_comb begin
    seg_d        = SEG_BLANK;
    dig_en_n_d   = DIG_OFF_N;
    scan_idx_d   = idx_d;
    frame_tick_d = (state_d == BLANK) && (idx_d == '0) && (cnt_d == '0);
    if (state_d == SHOW) begin
      seg_d      = rd_data;
      dig_en_n_d = digit_enable_n(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      dig_en_n_q   <= DIG_OFF_N;
      scan_idx_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dig_en_n_q   <= dig_en_n_d;
      scan_idx_q   <= scan_idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en_n   = dig_en_n_q;
  assign scan_idx   = scan_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_demux.sv
// Scoreboard bench for seg_scan_demux with CLK_DIV=4, BLANK_CYCLES=1.
module tb_seg_scan_demux;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] dig;
    logic [2:0] idx;
    logic       tick;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic       clr_all;
  logic       scan_en;
  logic [6:0] seg_out;
  logic [7:0] dig_en_n;
  logic [2:0] scan_idx;
  logic       frame_tick;

  int   total;
  int   bad;
  obs_t exp_q[$];
  obs_t got;
  obs_t want;
  logic [6:0] model_q [8];
  bit   scan_on;
  int   scan_t;

  seg_scan_demux #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_all    (clr_all),
    .scan_en    (scan_en),
    .seg_out    (seg_out),
    .dig_en_n   (dig_en_n),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t cycles after scan_en was first sampled high:
  // 4-cycle slots (1 dark + 3 lit), 8 slots per 32-cycle frame.
  function automatic obs_t exp_at(int t, bit on);
    obs_t e;
    int   slot;
    int   pos;
    e = '{seg: 7'h00, dig: 8'hFF, idx: 3'd0, tick: 1'b0};
    if (on) begin
      slot   = (t / 4) % 8;
      pos    = t % 4;
      e.idx  = 3'(slot);
      e.tick = ((t % 32) == 0);
      if (pos >= 1) begin
        e.seg = model_q[slot];
        e.dig = ~(8'h01 << slot);
      end
    end
    return e;
  endfunction

  // Pushes the expectation for the coming edge, then applies this cycle's
  // writes to the model (they become visible one cycle later) and clocks.
  task automatic model_step();
    if (scan_en) begin
      scan_t  = scan_on ? scan_t + 1 : 0;
      scan_on = 1'b1;
    end else begin
      scan_on = 1'b0;
      scan_t  = 0;
    end
    exp_q.push_back(exp_at(scan_t, scan_on));
    if (clr_all) begin
      for (int i = 0; i < 8; i++) model_q[i] = 7'h00;
      $display("clr_all (wr_en=%b addr=%0d data=%h)", wr_en, wr_addr, wr_data);
    end else if (wr_en) begin
      model_q[wr_addr] = wr_data;
      $display("wr addr=%0d data=%h", wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    clr_all = 1'b0;
    wr_addr = 3'd0;
    wr_data = 7'h00;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    scan_en = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    total++; if (seg_out !== 7'h00)  begin bad++; $display("FAIL reset_seg got=%h want=00", seg_out); end
    total++; if (dig_en_n !== 8'hFF) begin bad++; $display("FAIL reset_dig got=%h want=FF", dig_en_n); end
    total++; if (scan_idx !== 3'd0)  begin bad++; $display("FAIL reset_idx got=%0d want=0", scan_idx); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < 74; k++) begin
      idle_inputs();
      scan_en = (k >= 10);
      if (k < 8) begin
        wr_en   = 1'b1;
        wr_addr = 3'(k);
        wr_data = 7'(7'h3F - k);
      end
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL full_frame k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
    end
    $display("test_full_frame done");
  endtask

  task automatic test_live_write();
    for (int k = 0; k < 34; k++) begin
      idle_inputs();
      scan_en = (k >= 2);
      if (k == 16) begin
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 7'h06;
      end
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL live_write k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
    end
    $display("test_live_write done");
  endtask

  task automatic test_clear_vs_write();
    for (int k = 0; k < 34; k++) begin
      idle_inputs();
      scan_en = (k >= 2);
      if (k == 4) begin
        clr_all = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 7'h7F;
      end
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL clear_vs_write k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
    end
    $display("test_clear_vs_write done");
  endtask

  task automatic test_disable_mid_slot();
    for (int k = 0; k < 44; k++) begin
      idle_inputs();
      scan_en = (k >= 2 && k <= 27) || (k >= 31);
      if (k == 0) begin
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 7'h7D;
      end else if (k == 1) begin
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 7'h5B;
      end
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL disable k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
    end
    $display("test_disable_mid_slot done");
  endtask

  task automatic test_reset_mid_show();
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      scan_en = (k >= 2);
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pre_reset k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
    end
    // Slot 2 is lit now; reset must darken outputs without waiting for a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (dig_en_n !== 8'hFF) begin bad++; $display("FAIL midreset_dig got=%h want=FF", dig_en_n); end
    total++; if (seg_out !== 7'h00)  begin bad++; $display("FAIL midreset_seg got=%h want=00", seg_out); end
    total++; if (scan_idx !== 3'd0)  begin bad++; $display("FAIL midreset_idx got=%0d want=0", scan_idx); end
    scan_en = 1'b0;
    for (int i = 0; i < 8; i++) model_q[i] = 7'h00;
    scan_on = 1'b0;
    scan_t  = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 34; k++) begin
      idle_inputs();
      scan_en = (k >= 2);
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL post_reset k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
    end
    $display("test_reset_mid_show done");
  endtask

  task automatic test_invariant();
    logic [2:0] prev_idx;
    prev_idx = 3'd0;
    for (int k = 0; k < 138; k++) begin
      idle_inputs();
      scan_en = (k >= 2);
      if (k < 8) begin
        wr_en   = 1'b1;
        wr_addr = 3'(k);
        wr_data = 7'(7'h11 + 3 * k);
      end
      model_step();
      got  = {seg_out, dig_en_n, scan_idx, frame_tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL invariant k=%0d got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 k, got.seg, got.dig, got.idx, got.tick, want.seg, want.dig, want.idx, want.tick);
      end
      total++;
      if ($countones(~dig_en_n) > 1) begin
        bad++;
        $display("FAIL onecold k=%0d got dig=%h want at most one low bit", k, dig_en_n);
      end
      if (scan_idx !== prev_idx) begin
        total++;
        if (dig_en_n !== 8'hFF) begin
          bad++;
          $display("FAIL dark_at_change k=%0d idx %0d->%0d got dig=%h want FF", k, prev_idx, scan_idx, dig_en_n);
        end
      end
      prev_idx = scan_idx;
    end
    $display("test_invariant done");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    scan_on = 1'b0;
    scan_t  = 0;
    for (int i = 0; i < 8; i++) model_q[i] = 7'h00;
    test_reset();
    test_full_frame();
    test_live_write();
    test_clear_vs_write();
    test_disable_mid_slot();
    test_reset_mid_show();
    test_invariant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
